// File: rtl/bus_map_pkg.sv
// Shared address map for the data-bus target: register offsets, timer control
// bit positions and the decoder region type.
package bus_map_pkg;

  localparam int unsigned TIMER_WIDTH = 32;

  localparam logic [31:0] GPIO_OUT_OFFSET      = 32'h0000_0000;
  localparam logic [31:0] GPIO_IN_OFFSET       = 32'h0000_0004;
  localparam logic [31:0] TIMER_COUNT_OFFSET   = 32'h0000_0008;
  localparam logic [31:0] TIMER_COMPARE_OFFSET = 32'h0000_000C;
  localparam logic [31:0] TIMER_CTRL_OFFSET    = 32'h0000_0010;

  localparam int unsigned CTRL_ENABLE_BIT     = 0;
  localparam int unsigned CTRL_IRQ_ENABLE_BIT = 1;
  localparam int unsigned CTRL_FLAG_BIT       = 2;

  typedef enum logic [1:0] {
    Region_Ram        = 2'd0,
    Region_Peripheral = 2'd1,
    Region_None       = 2'd2
  } region_e;

endpackage

// File: rtl/bus_target_if.sv
// Single-cycle data bus: the master drives address/strobe/data, the target
// returns a combinational read word.
interface bus_target_if #(
  parameter int unsigned BUS_ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH    = 32
);
  logic [BUS_ADDRESS_WIDTH-1:0] address;
  logic                         write_enable;
  logic [BUS_DATA_WIDTH-1:0]    write_data;
  logic [BUS_DATA_WIDTH-1:0]    read_data;

  modport master (output address, output write_enable, output write_data,
                  input  read_data);
  modport slave  (input  address, input  write_enable, input  write_data,
                  output read_data);
endinterface

// File: rtl/bus_target_timer.sv
// 32-bit free-running timer with compare match, sticky W1C flag and level irq.
module bus_target_timer
  import bus_map_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TIMER_WIDTH-1:0] write_data_i,
  input  logic                   count_we_i,
  input  logic                   compare_we_i,
  input  logic                   ctrl_we_i,
  output logic [TIMER_WIDTH-1:0] count_o,
  output logic [TIMER_WIDTH-1:0] compare_o,
  output logic [TIMER_WIDTH-1:0] ctrl_o,
  output logic                   irq_o
);

  logic [TIMER_WIDTH-1:0] count_q, count_d;
  logic [TIMER_WIDTH-1:0] compare_q, compare_d;
  logic                   en_q, en_d;
  logic                   irq_en_q, irq_en_d;
  logic                   flag_q, flag_d;
  logic                   match;

  // Bus write to count beats the reload; a match set beats a W1C clear.
  always_comb begin
    match     = en_q && (count_q == compare_q);
    count_d   = count_q;
    compare_d = compare_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    flag_d    = flag_q;

    if (count_we_i) begin
      count_d = write_data_i;
    end else if (en_q) begin
      count_d = match ? '0 : count_q + TIMER_WIDTH'(1);
    end

    if (compare_we_i) begin
      compare_d = write_data_i;
    end

    if (ctrl_we_i) begin
      en_d     = write_data_i[CTRL_ENABLE_BIT];
      irq_en_d = write_data_i[CTRL_IRQ_ENABLE_BIT];
    end

    if (match) begin
      flag_d = 1'b1;
    end else if (ctrl_we_i && write_data_i[CTRL_FLAG_BIT]) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '1;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    ctrl_o                      = '0;
    ctrl_o[CTRL_ENABLE_BIT]     = en_q;
    ctrl_o[CTRL_IRQ_ENABLE_BIT] = irq_en_q;
    ctrl_o[CTRL_FLAG_BIT]       = flag_q;
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign irq_o     = flag_q & irq_en_q;

endmodule

// File: rtl/bus_target.sv
// Memory-side responder: decodes bus accesses into a word RAM or the GPIO/timer
// register bank, with combinational reads and clocked writes.
module bus_target
  import bus_map_pkg::*;
#(
  parameter int unsigned BUS_ADDRESS_WIDTH = 32,
  parameter int unsigned BUS_DATA_WIDTH    = 32,
  parameter int unsigned RAM_WORDS         = 64,
  parameter int unsigned GPIO_WIDTH        = 8,
  parameter int unsigned PERIPHERAL_BASE   = 'h800
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_target_if.slave           bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  localparam int unsigned ABW       = BUS_ADDRESS_WIDTH;
  localparam int unsigned DW        = BUS_DATA_WIDTH;
  localparam int unsigned RAM_IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned RAM_BYTES = RAM_WORDS * 4;

  logic [DW-1:0]         ram_q [RAM_WORDS];
  logic [GPIO_WIDTH-1:0] gpio_out_q;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;

  logic [ABW-1:0]        word_addr;
  logic [ABW-1:0]        reg_off;
  logic [RAM_IDX_W-1:0]  ram_idx;
  logic [1:0]            unused_addr_bits;
  region_e               region;

  logic ram_we, gpio_out_we, count_we, compare_we, ctrl_we;

  logic [TIMER_WIDTH-1:0] timer_count, timer_compare, timer_ctrl;
  logic                   timer_irq;

  assign word_addr        = {bus.address[ABW-1:2], 2'b00};
  assign reg_off          = word_addr - ABW'(PERIPHERAL_BASE);
  assign ram_idx          = bus.address[RAM_IDX_W+1:2];
  assign unused_addr_bits = bus.address[1:0];

  // Region decode; the register window ends at the last register.
  always_comb begin
    region = Region_None;
    if (word_addr < ABW'(RAM_BYTES)) begin
      region = Region_Ram;
    end else if ((word_addr >= ABW'(PERIPHERAL_BASE)) &&
                 (reg_off <= ABW'(TIMER_CTRL_OFFSET))) begin
      region = Region_Peripheral;
    end
  end

  always_comb begin
    ram_we      = 1'b0;
    gpio_out_we = 1'b0;
    count_we    = 1'b0;
    compare_we  = 1'b0;
    ctrl_we     = 1'b0;
    if (bus.write_enable && !reset) begin
      ram_we = (region == Region_Ram);
      if (region == Region_Peripheral) begin
        gpio_out_we = (reg_off == ABW'(GPIO_OUT_OFFSET));
        count_we    = (reg_off == ABW'(TIMER_COUNT_OFFSET));
        compare_we  = (reg_off == ABW'(TIMER_COMPARE_OFFSET));
        ctrl_we     = (reg_off == ABW'(TIMER_CTRL_OFFSET));
      end
    end
  end

  // RAM contents survive reset; only the write is suppressed.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[ram_idx] <= bus.write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (gpio_out_we) begin
        gpio_out_q <= bus.write_data[GPIO_WIDTH-1:0];
      end
    end
  end

  bus_target_timer u_timer (
    .clk          (clock),
    .reset        (reset),
    .write_data_i (TIMER_WIDTH'(bus.write_data)),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .ctrl_we_i    (ctrl_we),
    .count_o      (timer_count),
    .compare_o    (timer_compare),
    .ctrl_o       (timer_ctrl),
    .irq_o        (timer_irq)
  );

  always_comb begin
    bus.read_data = '0;
    case (region)
      Region_Ram: bus.read_data = ram_q[ram_idx];
      Region_Peripheral: begin
        if (reg_off == ABW'(GPIO_OUT_OFFSET))           bus.read_data = DW'(gpio_out_q);
        else if (reg_off == ABW'(GPIO_IN_OFFSET))       bus.read_data = DW'(sync2_q);
        else if (reg_off == ABW'(TIMER_COUNT_OFFSET))   bus.read_data = DW'(timer_count);
        else if (reg_off == ABW'(TIMER_COMPARE_OFFSET)) bus.read_data = DW'(timer_compare);
        else if (reg_off == ABW'(TIMER_CTRL_OFFSET))    bus.read_data = DW'(timer_ctrl);
      end
      default: bus.read_data = '0;
    endcase
  end

  assign gpio_out = gpio_out_q;
  assign irq      = timer_irq;

endmodule

// File: doc/bus_target.md
# bus_target

Memory-side responder for the CPU's simple single-cycle data bus (address, write_enable, write_data, read_data). Decodes each access into a word-addressed RAM or a small peripheral register bank: GPIO output, synchronised GPIO input, and a 32-bit timer with compare match and interrupt. Reads are combinational so the single-cycle core completes loads in the same cycle. Writes and all peripheral state update on the clock edge.

## Interface
- BUS_ADDRESS_WIDTH, 32, bus address width
- BUS_DATA_WIDTH, 32, bus data width; peripheral registers are 32-bit, zero-extended or truncated to this width
- RAM_WORDS, 64, RAM depth in words
- GPIO_WIDTH, 8, GPIO pin count (1..32)
- PERIPHERAL_BASE, 'h800, byte address of the peripheral register bank
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- address  input  BUS_ADDRESS_WIDTH  byte address; bits [1:0] ignored
- write_enable  input  1  write strobe, one word per asserted cycle
- write_data  input  BUS_DATA_WIDTH  write word
- read_data  output  BUS_DATA_WIDTH  combinational read word for current address
- gpio_in  input  GPIO_WIDTH  asynchronous input pins
- gpio_out  output  GPIO_WIDTH  registered output pins
- irq  output  1  timer interrupt, level

## Operation
- Map (byte addresses):
  - RAM: 0 .. RAM_WORDS*4-1, index address[…:2].
  - Registers at offsets from PERIPHERAL_BASE:
    - +0 GPIO_OUT, R/W.
    - +4 GPIO_IN, RO.
    - +8 TIMER_COUNT, R/W.
    - +C TIMER_COMPARE, R/W.
    - +10 TIMER_CTRL, R/W: bit0 enable, bit1 irq_enable, bit2 match flag. Writing 1 to bit2 clears the flag; writing 0 leaves it.
- Unmapped address: read_data = 0, write ignored, no side effects.
- Reads have no side effects.
- GPIO_IN value comes from a two-flop synchroniser; unused upper bits read 0.
- Timer, when enable=1, each cycle:
  - If count == compare: count → 0 and flag → 1.
  - Otherwise: count → count+1, modulo 2^32.
- Timer, when enable=0: count holds.
- irq = flag & irq_enable, registered-state derived; no extra latency.
- Priorities in one cycle:
  - A bus write to TIMER_COUNT overrides the increment/reload.
  - Flag set by a match overrides a same-cycle W1C clear.
  - A write to TIMER_COMPARE takes effect for the next cycle's comparison.
- Reset values:
  - gpio_out 0, synchroniser 0.
  - count 0, compare 'hFFFF_FFFF.
  - ctrl 0, irq 0.
  - read_data follows the address; RAM contents are not reset.

## Timing
- Read latency 0: read_data is valid in the same cycle as the address.
- A read of a location written in the previous cycle returns the new value.
- A read in the same cycle as a write to that location returns the old value.
- gpio_in change → visible in GPIO_IN read after 2 rising edges.
- GPIO_OUT write → gpio_out changes after the same edge.
- Timer enabled with compare=N from count 0:
  - Flag sets on edge N+1.
  - Period is N+1 cycles.
  - compare=0 sets the flag every cycle.
- Reset asserted mid-operation:
  - All registers return to reset values on that edge.
  - A coincident write is discarded, including RAM writes.

## Structure
- Shared package bus_map_pkg holds:
  - offset constants GPIO_OUT_OFFSET, GPIO_IN_OFFSET, TIMER_COUNT_OFFSET, TIMER_COMPARE_OFFSET, TIMER_CTRL_OFFSET;
  - ctrl bit indices;
  - a region enum {Region_Ram, Region_Peripheral, Region_None} for the address decoder.
- One sub-module, timer: owns count, compare, ctrl.
  - Inputs: write strobes per register plus write_data.
  - Outputs: register read values and irq.
- The top level holds the decoder, RAM array, GPIO, synchroniser, and read mux.

## Test plan
- Write 'hDEAD_BEEF to address 'h10, then read 'h10 and 'h13 → both return 'hDEAD_BEEF; reading 'h700 (unmapped) → 0, and a write there changes nothing.
- Write 'h1A5 to GPIO_OUT with GPIO_WIDTH=8 → gpio_out='hA5 after the edge; read back 'hA5. Set gpio_in='h3C → GPIO_IN reads 'h3C from the 2nd edge on, not the 1st.
- Reset, write compare=3, write ctrl='b011 → flag and irq rise after 4 edges and count=0. Write ctrl='b111 → flag clears, irq low; it re-asserts after another 4 edges.
- Force a match edge coinciding with a W1C write to ctrl → flag stays 1. Write TIMER_COUNT='h100 while enabled → next read 'h100, not 'h101.
- compare='hFFFF_FFFF, count written 'hFFFF_FFFE, enabled → 'hFFFF_FFFF, then 0 with flag set.
- Assert reset during a RAM write and with the timer running → write lost (the prior value is retained); count 0, ctrl 0, compare 'hFFFF_FFFF, gpio_out 0, irq 0.
